lpc_uart_target: RTL

Parametrised LPC I/O target exposing a 16550-style byte window (data + line status) at a configurable base address. It decodes LPC I/O read/write cycles on `lpc_clk` and feeds a one-byte TX holding register toward the UART transmitter. When the holding register is full, it stalls the host with long-wait SYNC, bounded by a timeout that ends in an error SYNC. It optionally buffers received bytes in a FIFO for host reads. It sits between the LPC bus pins and the UART TX/RX cores.

---
 rtl/lpc_pkg.sv | 46 ++++
 rtl/lpc_uart_target_rx_fifo.sv | 41 ++++
 rtl/lpc_uart_target.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC UART target: FSM states, LPC cycle codes,
// register offsets and LSR layout.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CTDIR,
    ST_ADDR,
    ST_WDATA0,
    ST_WDATA1,
    ST_HTAR0,
    ST_HTAR1,
    ST_SYNC,
    ST_RDATA0,
    ST_RDATA1,
    ST_PTAR0,
    ST_PTAR1
  } lpc_state_e;

  localparam logic [3:0] CT_IO_RD = 4'h0;
  localparam logic [3:0] CT_IO_WR = 4'h2;

  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_LWAIT = 4'h6;
  localparam logic [3:0] SYNC_ERR   = 4'hA;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_LSR  = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  // TEMT mirrors THRE: there is no shift register behind the holding register here.
  function automatic logic [7:0] lsr_value(input logic dr, input logic oe, input logic thre);
    logic [7:0] v;
    v = '0;
    v[LSR_DR]   = dr;
    v[LSR_OE]   = oe;
    v[LSR_THRE] = thre;
    v[LSR_TEMT] = thre;
    return v;
  endfunction

endpackage

// File: rtl/lpc_uart_target_rx_fifo.sv
// Byte FIFO for received UART data; rst is active-low and synchronous.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module lpc_rx_fifo #(
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(RX_DEPTH);

  logic [7:0]  mem [RX_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A push while full is only issued together with a pop, so the slot is free.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lpc_uart_target.sv
// LPC I/O target exposing a 16550-style data/LSR window with a TX holding register.
// Define LPC_UART_RX_EN to include the RX FIFO and overrun flag.
module lpc_uart_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h03F8,
  parameter int          RX_DEPTH  = 4,
  parameter int          WAIT_MAX  = 64
) (
  input  logic       lpc_clk,
  input  logic       lpc_rst,
  inout  wire  [3:0] lpc_data,
  input  logic       lpc_frame,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       lad_oe,
  output lpc_state_e state
);

  lpc_state_e  state_d;
  logic [3:0]  lad_in;
  logic [3:0]  lad_q, lad_d;
  logic        oe_d;
  logic [11:0] addr_sh, addr_sh_d;
  logic [15:0] addr_full;
  logic [1:0]  cnt, cnt_d;
  logic [2:0]  off, off_d;
  logic        is_wr, is_wr_d;
  logic [7:0]  wdata, wdata_d;
  logic [7:0]  wait_cnt, wait_d;
  logic        load_q, load_d;
  logic [3:0]  rd_hi, rd_hi_d;
  logic        sync_next;
  logic        tx_load;
  logic        hold_full_d;
  logic [7:0]  rd_val;
  logic        fifo_pop;
  logic        oe_clr;
  logic [7:0]  fifo_head;
  logic        fifo_empty;
  logic        oe_flag;

  assign lpc_data  = lad_oe ? lad_q : 4'bz;
  assign lad_in    = lpc_data;
  assign addr_full = {addr_sh, lad_in};

  // TX handshake: tx_data is transferred on every rising edge where
  // tx_valid && tx_ready; tx_valid stays high and tx_data stable until then.
  assign hold_full_d = tx_valid && !tx_ready;

  always_comb begin
    case (off)
      REG_DATA: rd_val = fifo_empty ? 8'h00 : fifo_head;
      REG_LSR:  rd_val = lsr_value(!fifo_empty, oe_flag, !tx_valid);
      default:  rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state;
    lad_d     = 4'hF;
    oe_d      = 1'b0;
    addr_sh_d = addr_sh;
    cnt_d     = cnt;
    off_d     = off;
    is_wr_d   = is_wr;
    wdata_d   = wdata;
    wait_d    = '0;
    load_d    = 1'b0;
    rd_hi_d   = rd_hi;
    sync_next = 1'b0;
    tx_load   = 1'b0;
    fifo_pop  = 1'b0;
    oe_clr    = 1'b0;
    case (state)
      ST_IDLE: state_d = ST_IDLE;
      ST_CTDIR: begin
        cnt_d = '0;
        if (lad_in == CT_IO_RD) begin
          is_wr_d = 1'b0;
          state_d = ST_ADDR;
        end else if (lad_in == CT_IO_WR) begin
          is_wr_d = 1'b1;
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        addr_sh_d = addr_full[11:0];
        cnt_d     = cnt + 2'd1;
        if (cnt == 2'd3) begin
          off_d = addr_full[2:0];
          if (addr_full[15:3] != BASE_ADDR[15:3]) state_d = ST_IDLE;
          else if (is_wr)                         state_d = ST_WDATA0;
          else                                    state_d = ST_HTAR0;
        end
      end
      ST_WDATA0: begin
        wdata_d[3:0] = lad_in;
        state_d      = ST_WDATA1;
      end
      ST_WDATA1: begin
        wdata_d[7:4] = lad_in;
        state_d      = ST_HTAR0;
      end
      ST_HTAR0: state_d = ST_HTAR1;
      ST_HTAR1: sync_next = 1'b1;
      ST_SYNC: begin
        tx_load = load_q;
        if (lad_q == SYNC_LWAIT) begin
          sync_next = 1'b1;
        end else if (lad_q == SYNC_ERR || is_wr) begin
          state_d = ST_PTAR0;
          oe_d    = 1'b1;
        end else begin
          state_d = ST_RDATA0;
          oe_d    = 1'b1;
          lad_d   = rd_val[3:0];
          rd_hi_d = rd_val[7:4];
        end
      end
      ST_RDATA0: begin
        state_d = ST_RDATA1;
        oe_d    = 1'b1;
        lad_d   = rd_hi;
      end
      ST_RDATA1: begin
        state_d = ST_PTAR0;
        oe_d    = 1'b1;
      end
      ST_PTAR0: begin
        state_d  = ST_PTAR1;
        fifo_pop = !is_wr && (off == REG_DATA) && !fifo_empty;
        oe_clr   = !is_wr && (off == REG_LSR);
      end
      ST_PTAR1: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // The SYNC nibble is registered, so each SYNC cycle's code is chosen one
    // edge ahead from whether the holding register will be empty in it.
    if (sync_next) begin
      state_d = ST_SYNC;
      oe_d    = 1'b1;
      if (!is_wr || off != REG_DATA || !hold_full_d) begin
        lad_d  = SYNC_READY;
        load_d = is_wr && (off == REG_DATA);
      end else if (wait_cnt == 8'(WAIT_MAX)) begin
        lad_d = SYNC_ERR;
      end else begin
        lad_d  = SYNC_LWAIT;
        wait_d = wait_cnt + 8'd1;
      end
    end

    if (!lpc_frame) begin
      state_d = (lad_in == 4'h0) ? ST_CTDIR : ST_IDLE;
      oe_d    = 1'b0;
      load_d  = 1'b0;
      tx_load = 1'b0;
    end
  end

  always_ff @(posedge lpc_clk) begin
    if (!lpc_rst) begin
      state    <= ST_IDLE;
      lad_q    <= 4'hF;
      lad_oe   <= 1'b0;
      addr_sh  <= '0;
      cnt      <= '0;
      off      <= '0;
      is_wr    <= 1'b0;
      wdata    <= '0;
      wait_cnt <= '0;
      load_q   <= 1'b0;
      rd_hi    <= '0;
    end else begin
      state    <= state_d;
      lad_q    <= lad_d;
      lad_oe   <= oe_d;
      addr_sh  <= addr_sh_d;
      cnt      <= cnt_d;
      off      <= off_d;
      is_wr    <= is_wr_d;
      wdata    <= wdata_d;
      wait_cnt <= wait_d;
      load_q   <= load_d;
      rd_hi    <= rd_hi_d;
    end
  end

  always_ff @(posedge lpc_clk) begin
    if (!lpc_rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (tx_load) begin
      tx_valid <= 1'b1;
      tx_data  <= wdata;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

`ifdef LPC_UART_RX_EN
  logic fifo_push;
  logic fifo_full;
  logic oe_q;

  assign fifo_push = rx_valid && (!fifo_full || fifo_pop);
  assign oe_flag   = oe_q;

  lpc_rx_fifo #(
    .RX_DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk  (lpc_clk),
    .rst  (lpc_rst),
    .push (fifo_push),
    .din  (rx_data),
    .pop  (fifo_pop),
    .head (fifo_head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // An overrun in the same cycle as an LSR read leaves OE set.
  always_ff @(posedge lpc_clk) begin
    if (!lpc_rst)                                oe_q <= 1'b0;
    else if (rx_valid && fifo_full && !fifo_pop) oe_q <= 1'b1;
    else if (oe_clr)                             oe_q <= 1'b0;
  end
`else
  logic unused_rx;
  assign unused_rx  = ^{rx_data, rx_valid, fifo_pop, oe_clr};
  assign fifo_head  = 8'h00;
  assign fifo_empty = 1'b1;
  assign oe_flag    = 1'b0;
`endif

endmodule
